// File: rtl/apb_timer_periph.sv
// APB-mapped timer: prescaler, auto-reload up-counter, match flag and level interrupt.
// Zero-wait-state slave; all state updates on the rising edge of PCLK.
module apb_timer_periph #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_TCR  = 3'd0,
    REG_PSC  = 3'd1,
    REG_ARR  = 3'd2,
    REG_TCNT = 3'd3,
    REG_TSR  = 3'd4
  } reg_sel_e;

  logic             r_en;
  logic             r_oneshot;
  logic             r_ie;
  logic [WIDTH-1:0] r_psc;
  logic [WIDTH-1:0] r_arr;
  logic [WIDTH-1:0] r_tcnt;
  logic [WIDTH-1:0] r_pcnt;
  logic             r_mf;
  logic             r_irq;

  logic [2:0]       w_sel;
  logic             w_access;
  logic             w_wr;
  logic             w_rd;
  logic             w_wr_tcr;
  logic             w_wr_psc;
  logic             w_wr_arr;
  logic             w_mf_w1c;
  logic             w_clr;
  logic             w_tick;
  logic             w_match;
  logic             w_unused;

  assign w_sel    = PADDR[4:2];
  assign w_unused = ^PADDR[1:0];
  assign w_access = PSEL & PENABLE;
  assign w_wr     = w_access & PWRITE;
  assign w_rd     = w_access & ~PWRITE;

  assign w_wr_tcr = w_wr && (w_sel == REG_TCR);
  assign w_wr_psc = w_wr && (w_sel == REG_PSC);
  assign w_wr_arr = w_wr && (w_sel == REG_ARR);
  assign w_mf_w1c = w_wr && (w_sel == REG_TSR) && PWDATA[0];
  assign w_clr    = w_wr_tcr & PWDATA[1];

  // A CLR write suppresses the tick, so no match (and no MF) on that edge.
  assign w_tick   = r_en && (r_pcnt == r_psc) && !w_clr;
  assign w_match  = w_tick && (r_tcnt == r_arr);

  assign PREADY   = w_access;
  assign irq      = r_irq;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_ie      <= 1'b0;
    end else if (w_wr_tcr) begin
      r_en      <= PWDATA[0];
      r_oneshot <= PWDATA[2];
      r_ie      <= PWDATA[3];
    end else if (w_match && r_oneshot) begin
      r_en      <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psc <= '0;
      r_arr <= '0;
    end else begin
      if (w_wr_psc) r_psc <= PWDATA[WIDTH-1:0];
      if (w_wr_arr) r_arr <= PWDATA[WIDTH-1:0];
    end
  end

  // TCNT free-runs through 2^WIDTH-1 when ARR is below it; only equality reloads.
  always_ff @(posedge PCLK) begin
    if (PRESET || w_clr) begin
      r_pcnt <= '0;
      r_tcnt <= '0;
    end else if (r_en) begin
      if (w_tick) begin
        r_pcnt <= '0;
        r_tcnt <= w_match ? '0 : r_tcnt + WIDTH'(1);
      end else begin
        r_pcnt <= r_pcnt + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_mf  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_match)       r_mf <= 1'b1;
      else if (w_mf_w1c) r_mf <= 1'b0;
      r_irq <= r_mf & r_ie;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_sel)
        REG_TCR:  PRDATA = {28'd0, r_ie, r_oneshot, 1'b0, r_en};
        REG_PSC:  PRDATA = 32'(r_psc);
        REG_ARR:  PRDATA = 32'(r_arr);
        REG_TCNT: PRDATA = 32'(r_tcnt);
        REG_TSR:  PRDATA = {31'd0, r_mf};
        default:  PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_periph.sv
// Scoreboard bench for apb_timer_periph: directed APB traffic pushes expected read
// data / irq levels into queues; a monitor thread pops and compares at negedge.
module tb_apb_timer_periph;

  localparam logic [4:0] A_TCR  = 5'h00;
  localparam logic [4:0] A_PSC  = 5'h04;
  localparam logic [4:0] A_ARR  = 5'h08;
  localparam logic [4:0] A_TCNT = 5'h0C;
  localparam logic [4:0] A_TSR  = 5'h10;
  localparam logic [4:0] A_BAD  = 5'h14;

  logic        PCLK    = 1'b0;
  logic        PRESET  = 1'b1;
  logic [4:0]  PADDR   = '0;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PWDATA  = '0;

  logic [31:0] prdata32, prdata8;
  logic        pready32, pready8;
  logic        irq32, irq8;

  apb_timer_periph u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata32), .PREADY(pready32), .irq(irq32)
  );

  apb_timer_periph #(.WIDTH(8)) u_dut8 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata8), .PREADY(pready8), .irq(irq8)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic [31:0] ev;
    int          at;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mark     = 0;
  bit   sel8     = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic monitor();
    exp_t        e;
    logic [31:0] prd;
    logic        prdy, pirq;
    forever begin
      @(negedge PCLK);
      prd  = sel8 ? prdata8 : prdata32;
      prdy = sel8 ? pready8 : pready32;
      pirq = sel8 ? irq8    : irq32;
      checks++;
      if (PSEL && PENABLE && !PWRITE) begin
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read: PRDATA=%h with no expectation queued", prd);
        end else begin
          e = rd_q.pop_front();
          if (prd !== e.ev || prdy !== 1'b1) begin
            failures++;
            $display("FAIL %s: PRDATA=%h PREADY=%b, required PRDATA=%h PREADY=1",
                     e.name, prd, prdy, e.ev);
          end
        end
      end else if (prd !== 32'h0 || prdy !== (PSEL && PENABLE)) begin
        failures++;
        $display("FAIL idle_bus @cyc %0d: PRDATA=%h PREADY=%b, required PRDATA=0 PREADY=%b",
                 cyc, prd, prdy, PSEL && PENABLE);
      end
      while (irq_q.size() != 0 && irq_q[0].at <= cyc) begin
        e = irq_q.pop_front();
        checks++;
        if (e.at != cyc || pirq !== e.ev[0]) begin
          failures++;
          $display("FAIL %s: irq=%b at cyc %0d, required irq=%b at cyc %0d",
                   e.name, pirq, cyc, e.ev[0], e.at);
        end
      end
    end
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    mark   = cyc;
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    mark = cyc;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_setup_only(input logic [4:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wait_to(input int k);
    while (cyc < mark + k) begin
      @(posedge PCLK); #1;
    end
  endtask

  // Read whose access phase observes the state right after the current edge + 1.
  task automatic rd(input logic [4:0] a, input logic [31:0] ev, input string nm);
    exp_t e;
    e.name = nm; e.ev = ev; e.at = 0;
    rd_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Read sampling the state just after edge mark+k.
  task automatic rd_at(input int k, input logic [4:0] a, input logic [31:0] ev, input string nm);
    if (cyc > mark + k - 1) begin
      checks++;
      failures++;
      $display("FAIL sched_%s: at cyc %0d, required at most %0d", nm, cyc, mark + k - 1);
    end
    wait_to(k - 1);
    rd(a, ev, nm);
  endtask

  task automatic irq_at(input int k, input logic ev, input string nm);
    exp_t e;
    e.name = nm; e.ev = {31'd0, ev}; e.at = mark + k;
    if (e.at < cyc) begin
      checks++;
      failures++;
      $display("FAIL sched_%s: at cyc %0d, required at most %0d", nm, cyc, e.at);
    end
    irq_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none

    do_reset();
    irq_at(1, 1'b0, "rst_irq");
    rd(A_TCR,  32'h0, "rst_tcr");
    rd(A_PSC,  32'h0, "rst_psc");
    rd(A_ARR,  32'h0, "rst_arr");
    rd(A_TCNT, 32'h0, "rst_tcnt");
    rd(A_TSR,  32'h0, "rst_tsr");

    // Register access corners
    apb_wr(A_PSC, 32'hABCD_EF12);
    rd(A_PSC, 32'hABCD_EF12, "psc_rw32");
    sel8 = 1'b1;
    rd(A_PSC, 32'h0000_0012, "psc_upper_bits_w8");
    sel8 = 1'b0;
    apb_setup_only(A_PSC, 32'h77);
    rd(A_PSC, 32'hABCD_EF12, "setup_phase_no_write");
    apb_wr(A_TCNT, 32'h55);
    rd(A_TCNT, 32'h0, "tcnt_write_ignored");
    apb_wr(A_BAD, 32'hFFFF_FFFF);
    rd(A_BAD, 32'h0, "unmapped_read");
    apb_wr(A_TCR, 32'hF);
    rd(A_TCR, 32'hD, "tcr_clr_reads0");

    // Periodic match with interrupt
    do_reset();
    apb_wr(A_PSC, 32'd3);
    apb_wr(A_ARR, 32'd4);
    apb_wr(A_TCR, 32'h9);
    irq_at(20, 1'b0, "irq_low_at_match");
    irq_at(21, 1'b1, "irq_rise_after_match");
    rd_at(19, A_TSR,  32'h0, "mf_before_match");
    rd_at(23, A_TCNT, 32'h0, "tcnt_reloaded");
    rd_at(25, A_TSR,  32'h1, "mf_after_match");
    rd_at(29, A_TCNT, 32'h2, "tcnt_continues");

    // One-shot
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd2);
    apb_wr(A_TCR, 32'h5);
    irq_at(6, 1'b0, "oneshot_irq_masked");
    rd_at(1,  A_TCNT, 32'h1, "oneshot_tcnt1");
    rd_at(3,  A_TSR,  32'h1, "oneshot_mf");
    rd_at(5,  A_TCR,  32'h4, "oneshot_en_cleared");
    rd_at(10, A_TCNT, 32'h0, "oneshot_tcnt_held");
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd2);
    apb_wr(A_TCR, 32'h5);
    rd_at(2, A_TCNT, 32'h2, "oneshot_tcnt2");

    // ARR written below TCNT: full wrap before the next match (8-bit instance)
    sel8 = 1'b1;
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd255);
    apb_wr(A_TCR, 32'h1);
    wait_to(8);
    apb_wr(A_ARR, 32'd5);
    rd_at(1,   A_TCNT, 32'd11,  "wrap_tcnt_after_arr");
    rd_at(245, A_TCNT, 32'd255, "wrap_tcnt_max");
    rd_at(247, A_TSR,  32'h0,   "wrap_no_mf");
    rd_at(249, A_TCNT, 32'd3,   "wrap_tcnt_restart");
    rd_at(251, A_TSR,  32'h0,   "wrap_mf_at_tcnt5");
    rd_at(253, A_TSR,  32'h1,   "wrap_mf_set");
    rd_at(255, A_TCNT, 32'd3,   "wrap_tcnt_reload");
    sel8 = 1'b0;

    // W1C colliding with a match, then a clean W1C
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd3);
    apb_wr(A_TCR, 32'h9);
    wait_to(2);
    apb_wr(A_TSR, 32'h1);
    irq_at(1, 1'b1, "collide_irq_high");
    rd_at(2, A_TSR, 32'h1, "collide_mf_wins");
    apb_wr(A_TSR, 32'h1);
    irq_at(0, 1'b1, "w1c_irq_still_high");
    irq_at(1, 1'b0, "w1c_irq_drops");
    rd_at(2, A_TSR, 32'h0, "w1c_mf_cleared");

    // CLR while running with a tick due on the same edge
    do_reset();
    apb_wr(A_PSC, 32'd1);
    apb_wr(A_ARR, 32'd200);
    apb_wr(A_TCR, 32'h1);
    wait_to(8);
    apb_wr(A_TCR, 32'h3);
    rd_at(1, A_TCNT, 32'h0, "clr_tcnt_zero");
    rd_at(3, A_TCR,  32'h1, "clr_en_kept");
    rd_at(5, A_TCNT, 32'h2, "clr_counting_resumes");

    // ARR=0 matches every tick; IE write 0 drops irq
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd0);
    apb_wr(A_TCR, 32'h1);
    rd_at(1, A_TCNT, 32'h0, "arr0_tcnt");
    rd_at(3, A_TSR,  32'h1, "arr0_mf");
    apb_wr(A_TCR, 32'h9);
    irq_at(1, 1'b1, "ie_on_irq_high");
    apb_wr(A_TCR, 32'h1);
    irq_at(0, 1'b1, "ie_off_irq_lag");
    irq_at(1, 1'b0, "ie_off_irq_low");
    rd_at(3, A_TSR,  32'h1, "ie_off_mf_kept");

    // Reset mid-count
    do_reset();
    apb_wr(A_PSC, 32'd0);
    apb_wr(A_ARR, 32'd8);
    apb_wr(A_TCR, 32'h9);
    irq_at(13, 1'b1, "pre_reset_irq");
    rd_at(16, A_TCNT, 32'd7, "pre_reset_tcnt7");
    do_reset();
    irq_at(0, 1'b0, "post_reset_irq");
    rd(A_TCR,  32'h0, "post_reset_tcr");
    rd(A_PSC,  32'h0, "post_reset_psc");
    rd(A_ARR,  32'h0, "post_reset_arr");
    rd(A_TCNT, 32'h0, "post_reset_tcnt");
    rd(A_TSR,  32'h0, "post_reset_tsr");
    rd(A_BAD,  32'h0, "post_reset_unmapped");
    rd_at(20, A_TCNT, 32'h0, "post_reset_stopped");

    for (int i = 0; i < 20 && (rd_q.size() != 0 || irq_q.size() != 0); i++) begin
      @(posedge PCLK); #1;
    end
    checks++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      failures++;
      $display("FAIL drain: rd_q=%0d irq_q=%0d entries left, required 0", rd_q.size(), irq_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_timer_periph.md
APB_TIMER_PERIPH -- requirements
Module: apb_timer_periph

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter, prescaler and auto-reload width (1..32).
REQ-002 SHALL have port PCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESET, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port PADDR, input, 5: APB byte address; bits [4:2] select the register.
REQ-005 SHALL have port PSEL, input, 1: APB select.
REQ-006 SHALL have port PENABLE, input, 1: APB access phase.
REQ-007 SHALL have port PWRITE, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port PWDATA, input, 32: write data.
REQ-009 SHALL have port PRDATA, output, 32: read data.
REQ-010 SHALL have port PREADY, output, 1: transfer complete.
REQ-011 SHALL have port irq, output, 1: timer interrupt, level, registered.

Function
REQ-012 Register map SHALL be:
- 0x00 TCR: bit0 EN, bit1 CLR (write-only, self-clearing, reads 0), bit2 ONESHOT, bit3 IE.
- 0x04 PSC: R/W.
- 0x08 ARR: R/W.
- 0x0C TCNT: read-only.
- 0x10 TSR: bit0 MF, write-1-to-clear.
- Other offsets: read 0, writes ignored.
REQ-013 PREADY SHALL equal PSEL & PENABLE; zero wait states.
REQ-014 Register writes SHALL commit on the edge where PSEL & PENABLE & PWRITE = 1; setup phase (PENABLE=0) SHALL have no effect.
REQ-015 PRDATA SHALL carry the selected register, zero-extended to 32 bits, when PSEL & PENABLE & !PWRITE, and SHALL be 0 otherwise.
REQ-016 PSC, ARR and TCNT SHALL use bits [WIDTH-1:0] of PWDATA; upper bits SHALL be ignored on write and read as 0.
REQ-017 Prescaler counter pcnt SHALL increment each cycle while EN=1; when pcnt==PSC it SHALL return to 0 and generate a one-cycle tick. PSC=0 SHALL give a tick every enabled cycle.
REQ-018 On each tick:
- If TCNT==ARR: TCNT SHALL go to 0 and MF SHALL be set.
- Otherwise TCNT SHALL increment by 1.
- ARR=0 SHALL set MF on every tick.
REQ-019 If ARR is written below the current TCNT, TCNT SHALL count on to 2^WIDTH-1, wrap to 0 without setting MF, and then match ARR normally.
REQ-020 With ONESHOT=1, the tick that sets MF SHALL also clear EN in the same cycle; TCNT SHALL stay at 0.
REQ-021 While EN=0, pcnt and TCNT SHALL hold their values.
REQ-022 A write of CLR=1 SHALL zero pcnt and TCNT on that edge, with priority over a simultaneous tick. EN, ONESHOT and IE SHALL take the written value.
REQ-023 If a hardware MF set and a W1C of MF occur in the same cycle, MF SHALL end at 1.
REQ-024 irq SHALL be registered as MF & IE, so it asserts one cycle after MF is set, and SHALL stay high until MF is cleared or IE is written 0.
REQ-025 Writes to TCNT SHALL be ignored.

Reset
REQ-026 With PRESET=1 at an edge, TCR, PSC, ARR, TCNT, pcnt, MF and irq SHALL all become 0. Reset SHALL abort counting mid-operation.
REQ-027 PRDATA and PREADY SHALL follow REQ-013 and REQ-015 during and after reset, so both read 0 when not selected.

Verification
REQ-028 Write PSC=3, ARR=4, TCR=0x9 -> MF sets 20 cycles after the enabling write; irq rises 1 cycle later; TCNT reads 0 and counting continues.
REQ-029 Write PSC=0, ARR=2, TCR=0x5 -> TCNT goes 1, 2, 0; MF=1; EN reads 0; TCNT stays 0 thereafter.
REQ-030 Running with TCNT=10: write ARR=5 -> TCNT continues to 2^32-1, wraps to 0 with MF still 0, then MF sets when TCNT reaches 5.
REQ-031 Issue a W1C of TSR on the same cycle as a match -> MF reads 1 afterwards; a later W1C reads MF=0 and irq drops 1 cycle later.
REQ-032 Write TCR=0x3 while running, with a tick due the same cycle -> TCNT reads 0 and EN remains 1.
REQ-033 Assert PRESET mid-count with TCNT=7 -> all registers read 0 and irq=0; a read of offset 0x14 returns 0 with PREADY=1.
